// File: rtl/chkdigit_sched.sv
// Round-robin scheduler sharing one streaming check-digit engine among NUM_REQ requesters.
// Define CHKDIGIT_SCHED_STATS_EN to add saturating response/error counters (stat_done, stat_err).
module chkdigit_sched #(
    parameter int NUM_REQ = 4,
    parameter int DIGITS  = 15,
    parameter int TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*4*DIGITS-1:0]   req_code,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [3:0]                    eng_in_num,
    output logic                          eng_in_valid,
    input  logic [3:0]                    eng_out,
    input  logic                          eng_out_valid,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic [3:0]                    resp_digit,
    output logic                          resp_err,
    output logic                          busy
`ifdef CHKDIGIT_SCHED_STATS_EN
    ,
    output logic [15:0]                   stat_done,
    output logic [15:0]                   stat_err
`endif
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int CODEW = 4 * DIGITS;
    localparam int KW    = $clog2(DIGITS + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [CODEW-1:0] code_q, code_d;
    logic [KW-1:0]    k_q, k_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [3:0]       resp_digit_q, resp_digit_d;
    logic             resp_err_q, resp_err_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   grant_next_ptr;

    // Circular search for the first valid requester at or after the RR pointer.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req_valid[IDW'(idx)]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign grant_next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // The latched code is shifted left each STREAM cycle so the top nibble is always digit k.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        code_d       = code_q;
        k_d          = k_q;
        timer_d      = timer_q;
        resp_digit_d = resp_digit_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    id_d    = grant_id;
                    code_d  = req_code[int'(grant_id)*CODEW +: CODEW];
                    ptr_d   = grant_next_ptr;
                    k_d     = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                code_d = code_q << 4;
                k_d    = k_q + 1'b1;
                if (k_q == KW'(DIGITS - 1)) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (eng_out_valid) begin
                    resp_digit_d = eng_out;
                    resp_err_d   = (eng_out == 4'hF);
                    state_d      = ST_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    resp_digit_d = 4'hF;
                    resp_err_d   = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            code_q       <= '0;
            k_q          <= '0;
            timer_q      <= '0;
            resp_digit_q <= 4'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            code_q       <= code_d;
            k_q          <= k_d;
            timer_q      <= timer_d;
            resp_digit_q <= resp_digit_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // req_ready is combinational from req_valid, so it is masked while reset is held.
    assign req_ready    = (state_q == ST_IDLE && grant_found && !rst)
                          ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;
    assign eng_in_valid = (state_q == ST_STREAM);
    assign eng_in_num   = (state_q == ST_STREAM) ? code_q[CODEW-1 -: 4] : 4'd0;
    assign resp_valid   = (state_q == ST_RESP);
    assign resp_id      = id_q;
    assign resp_digit   = resp_digit_q;
    assign resp_err     = resp_err_q;
    assign busy         = (state_q != ST_IDLE);

`ifdef CHKDIGIT_SCHED_STATS_EN
    logic [15:0] stat_done_q;
    logic [15:0] stat_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_done_q <= 16'd0;
            stat_err_q  <= 16'd0;
        end else if (state_q == ST_RESP && resp_ready) begin
            if (stat_done_q != 16'hFFFF) begin
                stat_done_q <= stat_done_q + 16'd1;
            end
            if (resp_err_q && stat_err_q != 16'hFFFF) begin
                stat_err_q <= stat_err_q + 16'd1;
            end
        end
    end

    assign stat_done = stat_done_q;
    assign stat_err  = stat_err_q;
`endif

endmodule

// File: tb/tb_chkdigit_sched.sv
// Directed testbench for chkdigit_sched with a Luhn-style engine stub.
// The stub answers one cycle after the last digit unless engSilent is set.
module tb_chkdigit_sched;

    localparam int NUM_REQ = 4;
    localparam int DIGITS  = 15;
    localparam int TIMEOUT = 4;
    localparam int CODEW   = 4 * DIGITS;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_REQ-1:0]          req_valid = '0;
    logic [NUM_REQ*CODEW-1:0]    req_code = '0;
    logic [NUM_REQ-1:0]          req_ready;
    logic [3:0]                  eng_in_num;
    logic                        eng_in_valid;
    logic [3:0]                  eng_out;
    logic                        eng_out_valid;
    logic                        resp_valid;
    logic                        resp_ready = 1'b1;
    logic [1:0]                  resp_id;
    logic [3:0]                  resp_digit;
    logic                        resp_err;
    logic                        busy;
`ifdef CHKDIGIT_SCHED_STATS_EN
    logic [15:0]                 stat_done;
    logic [15:0]                 stat_err;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic        engSilent = 1'b0;
    int          capCount;
    logic [55:0] capCode;
    logic [59:0] lastStreamCode;
    int          runLen = 0;

    always #5 clk = ~clk;

    chkdigit_sched #(
        .NUM_REQ (NUM_REQ),
        .DIGITS  (DIGITS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_code      (req_code),
        .req_ready     (req_ready),
        .eng_in_num    (eng_in_num),
        .eng_in_valid  (eng_in_valid),
        .eng_out       (eng_out),
        .eng_out_valid (eng_out_valid),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_digit    (resp_digit),
        .resp_err      (resp_err),
        .busy          (busy)
`ifdef CHKDIGIT_SCHED_STATS_EN
        ,
        .stat_done     (stat_done),
        .stat_err      (stat_err)
`endif
    );

    // Luhn check over 15 digits, digit 0 most significant; the rightmost digit is doubled.
    function automatic logic [3:0] luhnOf(input logic [59:0] code);
        int sum;
        int d;
        sum = 0;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(code[59 - 4*i -: 4]);
            if ((i % 2) == 0) begin
                d = 2 * d;
                if (d > 9) d = d - 9;
            end
            sum = sum + d;
        end
        if (code == 60'd0) return 4'hF;
        return 4'((10 - (sum % 10)) % 10);
    endfunction

    // Engine stub: collects the streamed digits and answers in the following cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_out_valid  <= 1'b0;
            eng_out        <= 4'd0;
            capCount       <= 0;
            capCode        <= '0;
            lastStreamCode <= '0;
        end else begin
            eng_out_valid <= 1'b0;
            if (eng_in_valid) begin
                capCode <= {capCode[51:0], eng_in_num};
                if (capCount == DIGITS - 1) begin
                    capCount       <= 0;
                    lastStreamCode <= {capCode, eng_in_num};
                    if (!engSilent) begin
                        eng_out_valid <= 1'b1;
                        eng_out       <= luhnOf({capCode, eng_in_num});
                    end
                end else begin
                    capCount <= capCount + 1;
                end
            end else begin
                capCount <= 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every eng_in_valid burst must be exactly DIGITS cycles long.
    always @(negedge clk) begin
        if (rst) begin
            runLen = 0;
        end else if (eng_in_valid) begin
            runLen++;
        end else if (runLen != 0) begin
            checkOutput("stream_run_len", 64'(runLen), 64'(DIGITS));
            runLen = 0;
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic ready);
        req_valid  = valid;
        resp_ready = ready;
        #1;
    endtask

    task automatic setCode(input int id, input logic [59:0] code);
        req_code[id*CODEW +: CODEW] = code;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        checkOutput({tag, "_eng_in_valid"}, 64'(eng_in_valid), 64'd0);
        checkOutput({tag, "_eng_in_num"}, 64'(eng_in_num), 64'd0);
        checkOutput({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        checkOutput({tag, "_resp_id"}, 64'(resp_id), 64'd0);
        checkOutput({tag, "_resp_digit"}, 64'(resp_digit), 64'd0);
        checkOutput({tag, "_resp_err"}, 64'(resp_err), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // One complete job with the engine answering at nominal latency; DUT must be IDLE on entry.
    task automatic serveJob(input int id, input logic [59:0] code, input logic [3:0] expDigit, input logic expErr);
        setCode(id, code);
        applyStimulus(4'(1 << id), 1'b1);
        checkOutput($sformatf("grant_r%0d", id), 64'(req_ready), 64'(1 << id));
        checkOutput("idle_busy", 64'(busy), 64'd0);
        stepCycle();
        applyStimulus(4'b0000, 1'b1);
        for (int k = 0; k < DIGITS; k++) begin
            checkOutput($sformatf("stream_valid_k%0d", k), 64'(eng_in_valid), 64'd1);
            checkOutput($sformatf("stream_digit_k%0d", k), 64'(eng_in_num), 64'(code[59 - 4*k -: 4]));
            stepCycle();
        end
        checkOutput("wait_eng_in_valid", 64'(eng_in_valid), 64'd0);
        checkOutput("wait_resp_valid", 64'(resp_valid), 64'd0);
        stepCycle();
        checkOutput("resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("resp_id", 64'(resp_id), 64'(id));
        checkOutput("resp_digit", 64'(resp_digit), 64'(expDigit));
        checkOutput("resp_err", 64'(resp_err), 64'(expErr));
        checkOutput("streamed_code", 64'(lastStreamCode), 64'(code));
        stepCycle();
        checkOutput("after_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("after_resp_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [59:0] rrCode [0:3];
        int          rrIds  [0:4];
        logic [3:0]  rrDig  [0:4];

        rrCode = '{60'h100000000000000, 60'h200000000000000,
                   60'h300000000000000, 60'h400000000000000};
        rrIds  = '{0, 1, 2, 3, 0};
        rrDig  = '{4'd8, 4'd6, 4'd4, 4'd2, 4'd8};

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;

        // Single requests, including the all-zero code the engine rejects
        serveJob(0, 60'h100000000000000, 4'd8, 1'b0);
        serveJob(2, 60'h030000000000000, 4'd7, 1'b0);
        serveJob(1, 60'h000000000000000, 4'hF, 1'b1);

        // Reset so the round-robin order starts at requester 0
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) setCode(i, rrCode[i]);
        applyStimulus(4'b1111, 1'b1);
        for (int j = 0; j < 5; j++) begin
            checkOutput($sformatf("rr_grant_%0d", j), 64'(req_ready), 64'(1 << rrIds[j]));
            checkOutput($sformatf("rr_idle_eng_%0d", j), 64'(eng_in_valid), 64'd0);
            repeat (17) stepCycle();
            checkOutput($sformatf("rr_resp_valid_%0d", j), 64'(resp_valid), 64'd1);
            checkOutput($sformatf("rr_resp_id_%0d", j), 64'(resp_id), 64'(rrIds[j]));
            checkOutput($sformatf("rr_resp_digit_%0d", j), 64'(resp_digit), 64'(rrDig[j]));
            checkOutput($sformatf("rr_req_ready_%0d", j), 64'(req_ready), 64'd0);
            if (j == 4) applyStimulus(4'b0000, 1'b1);
            stepCycle();
        end
        checkOutput("rr_end_busy", 64'(busy), 64'd0);

        // Silent engine: timeout after TIMEOUT wait cycles
        engSilent = 1'b1;
        setCode(1, 60'h100000000000000);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("to_grant", 64'(req_ready), 64'b0010);
        stepCycle();
        applyStimulus(4'b0000, 1'b1);
        repeat (15) stepCycle();
        checkOutput("to_wait0_resp_valid", 64'(resp_valid), 64'd0);
        repeat (3) stepCycle();
        checkOutput("to_wait3_resp_valid", 64'(resp_valid), 64'd0);
        stepCycle();
        checkOutput("to_resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("to_resp_id", 64'(resp_id), 64'd1);
        checkOutput("to_resp_digit", 64'(resp_digit), 64'hF);
        checkOutput("to_resp_err", 64'(resp_err), 64'd1);
        stepCycle();
        checkOutput("to_after_busy", 64'(busy), 64'd0);
        engSilent = 1'b0;
        serveJob(3, 60'h400000000000000, 4'd2, 1'b0);

        // Stalled consumer: response held, no new grant
        setCode(0, 60'h100000000000000);
        setCode(1, 60'h500000000000000);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("stall_grant", 64'(req_ready), 64'b0001);
        stepCycle();
        applyStimulus(4'b0010, 1'b0);
        repeat (16) stepCycle();
        checkOutput("stall_resp_valid", 64'(resp_valid), 64'd1);
        for (int c = 0; c < 10; c++) begin
            stepCycle();
            checkOutput($sformatf("stall_valid_%0d", c), 64'(resp_valid), 64'd1);
            checkOutput($sformatf("stall_id_%0d", c), 64'(resp_id), 64'd0);
            checkOutput($sformatf("stall_digit_%0d", c), 64'(resp_digit), 64'd8);
            checkOutput($sformatf("stall_err_%0d", c), 64'(resp_err), 64'd0);
            checkOutput($sformatf("stall_req_ready_%0d", c), 64'(req_ready), 64'd0);
        end
        applyStimulus(4'b0010, 1'b1);
        stepCycle();
        checkOutput("post_stall_grant", 64'(req_ready), 64'b0010);
        repeat (5) stepCycle();
        checkOutput("mid_stream_valid", 64'(eng_in_valid), 64'd1);

        // Asynchronous reset mid-stream with requester 1 still requesting
        #2 rst = 1'b1;
        #1;
        checkResetOutputs("async_reset");
        stepCycle();
        rst = 1'b0;
        applyStimulus(4'b0011, 1'b1);
        checkOutput("after_reset_grant", 64'(req_ready), 64'b0001);
        stepCycle();
        applyStimulus(4'b0000, 1'b1);
        repeat (16) stepCycle();
        checkOutput("after_reset_resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("after_reset_resp_id", 64'(resp_id), 64'd0);
        checkOutput("after_reset_resp_digit", 64'(resp_digit), 64'd8);
        stepCycle();
        checkOutput("final_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/chkdigit_sched.md
Name: chkdigit_sched

Overview:
- Round-robin scheduler that shares one streaming check-digit engine among NUM_REQ requesters.
- Each requester presents a packed DIGITS-digit BCD code. The scheduler grants one requester, streams its digits into the engine one per cycle and captures the engine's check digit. It then returns the result, tagged with the requester id.
- Sits between the requester-side logic and a single check-digit engine instance. The engine has one digit input with a valid strobe, and one result output with a valid strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIGITS, 15, digits per code; must match the engine's count.
- TIMEOUT, 4, WAIT cycles allowed for the engine result before an error response is issued.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester code valid.
- req_code  in  NUM_REQ*4*DIGITS  packed codes; requester i occupies slice [i*4*DIGITS +: 4*DIGITS].
- req_ready  out  NUM_REQ  one-hot acceptance pulse.
- eng_in_num  out  4  digit to engine.
- eng_in_valid  out  1  digit strobe to engine.
- eng_out  in  4  engine check digit.
- eng_out_valid  in  1  engine result strobe.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  $clog2(NUM_REQ)  id of the served requester.
- resp_digit  out  4  check digit; 4'hF on error.
- resp_err  out  1  1 = engine returned 15 or timed out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: req_ready=0, eng_in_valid=0, eng_in_num=0, resp_valid=0, resp_id=0, resp_digit=0, resp_err=0, busy=0. State returns to IDLE and the RR pointer to 0.
- Reset mid-operation aborts the job with no response. The engine is not otherwise notified, because eng_in_valid low restarts it.

State machine:
- IDLE:
  - If any req_valid is set, grant the first requester at or after the RR pointer, searching circularly.
  - Latch its code and id, and drive req_ready[id]=1 for this single cycle.
  - Set the pointer to id+1, wrapping at NUM_REQ.
  - Go to STREAM with k=0.
- STREAM:
  - eng_in_valid=1; eng_in_num=digit k, where digit 0 is the most significant nibble of the latched code.
  - k increments each cycle. At k=DIGITS-1 go to WAIT.
  - Exactly DIGITS consecutive valid cycles, no bubbles.
- WAIT:
  - eng_in_valid=0 and eng_in_num=0; timer counts up from 0.
  - On eng_out_valid: latch eng_out into resp_digit, set resp_err=(eng_out==4'hF), go to RESP.
  - When timer reaches TIMEOUT-1 with no strobe: resp_digit=4'hF, resp_err=1, go to RESP.
- RESP:
  - resp_valid=1; resp_id, resp_digit and resp_err are held stable until resp_ready=1.
  - The cycle with resp_valid && resp_ready completes the transfer; the next state is IDLE.

Timing and boundary rules:
- Nominal latency: acceptance in cycle T, digits in T+1..T+DIGITS, engine result in T+DIGITS+1, resp_valid from T+DIGITS+2.
- Back-to-back jobs are separated by at least one IDLE cycle. That cycle, plus WAIT and RESP, keeps eng_in_valid low so the engine restarts its count.
- req_valid and req_code changes are ignored outside IDLE; the code is latched at grant.
- A requester must hold req_valid until it sees req_ready.
- eng_out_valid outside WAIT is ignored.
- Simultaneous requests are arbitrated by RR order only. A single active requester is re-granted every job.

Optional Feature:
- Macro: CHKDIGIT_SCHED_STATS_EN.
- Defined: adds outputs stat_done[15:0] and stat_err[15:0], both reset to 0.
  - stat_done increments on every completed response handshake.
  - stat_err increments on handshakes where resp_err=1.
  - Both saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request, req_code[0]=60'h100000000000000 (digit0=1, rest 0) -> req_ready[0] pulses once; 15 eng_in_valid cycles with digits 1,0,...,0; then resp_valid with resp_id=0, resp_digit=8, resp_err=0 at T+17.
- Requester 2, code 60'h030000000000000 -> resp_id=2, resp_digit=7, resp_err=0.
- All-zero code -> engine returns 15 -> resp_digit=4'hF, resp_err=1.
- All four req_valid held high, resp_ready=1 -> grants in order 0,1,2,3,0; one idle cycle between jobs; eng_in_valid never high outside STREAM.
- Engine stub that never raises eng_out_valid -> after 4 WAIT cycles resp_err=1, resp_digit=4'hF; the next request is then served normally.
- resp_ready held low for 10 cycles -> response fields stable; no new req_ready. Then assert rst mid-STREAM -> all outputs return to reset values immediately, and the next grant goes to requester 0.
